// File: rtl/cisc_state_seq_if.sv
// Control/status bundle for the CISC control-step state register.
// The master drives step requests; the slave (the register) returns its state view.
interface cisc_state_seq_if #(
  parameter int STATE_W = 3,
  parameter int CNT_W   = 8
);
  logic               en;
  logic               load;
  logic [STATE_W-1:0] state_in;
  logic               adv;
  logic               illegal_clr;
  logic [STATE_W-1:0] state_out;
  logic [STATE_W-1:0] prev_state;
  logic [CNT_W-1:0]   dwell_cnt;
  logic               changed;
  logic               illegal;

  modport master (
    output en, load, state_in, adv, illegal_clr,
    input  state_out, prev_state, dwell_cnt, changed, illegal
  );

  modport slave (
    input  en, load, state_in, adv, illegal_clr,
    output state_out, prev_state, dwell_cnt, changed, illegal
  );
endinterface

// File: rtl/cisc_state_seq.sv
// Instruction-cycle state register: load/advance with wrap, stall gating,
// illegal-load rejection, previous-state history, dwell counter and change pulse.
module cisc_state_seq #(
  parameter int STATE_W     = 3,
  parameter int NUM_STATES  = 6,
  parameter int RESET_STATE = 0,
  parameter int CNT_W       = 8
) (
  input logic            clk,
  input logic            reset,
  cisc_state_seq_if.slave bus
);

  // One extra bit so NUM_STATES == 2**STATE_W is representable.
  localparam logic [STATE_W:0]   NUM_L   = (STATE_W+1)'(NUM_STATES);
  localparam logic [STATE_W-1:0] LAST_S  = STATE_W'(NUM_STATES - 1);
  localparam logic [STATE_W-1:0] RESET_S = STATE_W'(RESET_STATE);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] prev_q;
  logic [CNT_W-1:0]   dwell_q;
  logic               changed_q;
  logic               illegal_q;

  logic [STATE_W-1:0] state_nxt;
  logic               load_ok;
  logic               load_bad;
  logic               change;

  always_comb begin
    state_nxt = state_q;
    load_ok   = bus.load && ({1'b0, bus.state_in} < NUM_L);
    load_bad  = bus.load && !load_ok;
    change    = 1'b0;
    if (bus.en) begin
      if (bus.load) begin
        if (load_ok) state_nxt = bus.state_in;
      end else if (bus.adv) begin
        state_nxt = (state_q == LAST_S) ? '0 : state_q + 1'b1;
      end
      change = (state_nxt != state_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= RESET_S;
      prev_q    <= RESET_S;
      dwell_q   <= '0;
      changed_q <= 1'b0;
      illegal_q <= 1'b0;
    end else if (bus.en) begin
      state_q <= state_nxt;
      if (change) begin
        prev_q    <= state_q;
        dwell_q   <= '0;
        changed_q <= 1'b1;
      end else begin
        changed_q <= 1'b0;
        if (dwell_q != '1) dwell_q <= dwell_q + 1'b1;
      end
      // A rejected load in the same cycle wins over a clear request.
      if (load_bad)             illegal_q <= 1'b1;
      else if (bus.illegal_clr) illegal_q <= 1'b0;
    end else begin
      changed_q <= 1'b0;
    end
  end

  assign bus.state_out  = state_q;
  assign bus.prev_state = prev_q;
  assign bus.dwell_cnt  = dwell_q;
  assign bus.changed    = changed_q;
  assign bus.illegal    = illegal_q;

endmodule

// File: tb/tb_cisc_state_seq.sv
// Directed bench for cisc_state_seq: default instance plus a CNT_W=3 instance
// for dwell saturation.
module tb_cisc_state_seq;
  logic clk;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  cisc_state_seq_if #(.STATE_W(3), .CNT_W(8)) b ();
  cisc_state_seq_if #(.STATE_W(3), .CNT_W(3)) b3 ();

  cisc_state_seq dut (.clk(clk), .reset(reset), .bus(b.slave));
  cisc_state_seq #(.CNT_W(3)) dut3 (.clk(clk), .reset(reset), .bus(b3.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    b.en = 1'b1; b.load = 1'b0; b.state_in = '0; b.adv = 1'b0; b.illegal_clr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    b.adv = 1'b1; b.load = 1'b1; b.state_in = 3'd3;
    tick(); tick();
    n_cmp++; if (b.state_out !== 3'd0) begin n_err++; $display("FAIL reset_state got=%0d exp=0", b.state_out); end
    n_cmp++; if (b.prev_state !== 3'd0) begin n_err++; $display("FAIL reset_prev got=%0d exp=0", b.prev_state); end
    n_cmp++; if (b.dwell_cnt !== 8'd0) begin n_err++; $display("FAIL reset_dwell got=%0d exp=0", b.dwell_cnt); end
    n_cmp++; if (b.changed !== 1'b0) begin n_err++; $display("FAIL reset_changed got=%b exp=0", b.changed); end
    n_cmp++; if (b.illegal !== 1'b0) begin n_err++; $display("FAIL reset_illegal got=%b exp=0", b.illegal); end
    idle();
    reset = 1'b1;
  endtask

  task automatic test_advance_wrap();
    logic [2:0] exp_s [7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1};
    logic [2:0] exp_p [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
    b.adv = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      n_cmp++; if (b.state_out !== exp_s[i]) begin n_err++; $display("FAIL adv_state[%0d] got=%0d exp=%0d", i, b.state_out, exp_s[i]); end
      n_cmp++; if (b.prev_state !== exp_p[i]) begin n_err++; $display("FAIL adv_prev[%0d] got=%0d exp=%0d", i, b.prev_state, exp_p[i]); end
      n_cmp++; if (b.changed !== 1'b1) begin n_err++; $display("FAIL adv_changed[%0d] got=%b exp=1", i, b.changed); end
      n_cmp++; if (b.dwell_cnt !== 8'd0) begin n_err++; $display("FAIL adv_dwell[%0d] got=%0d exp=0", i, b.dwell_cnt); end
    end
    idle();
  endtask

  task automatic test_load_priority();
    b.load = 1'b1; b.state_in = 3'd4; b.adv = 1'b1;
    tick();
    n_cmp++; if (b.state_out !== 3'd4) begin n_err++; $display("FAIL loadpri_state got=%0d exp=4", b.state_out); end
    n_cmp++; if (b.prev_state !== 3'd1) begin n_err++; $display("FAIL loadpri_prev got=%0d exp=1", b.prev_state); end
    n_cmp++; if (b.changed !== 1'b1) begin n_err++; $display("FAIL loadpri_changed got=%b exp=1", b.changed); end
    b.adv = 1'b0;
    tick();
    n_cmp++; if (b.state_out !== 3'd4) begin n_err++; $display("FAIL loadsame_state got=%0d exp=4", b.state_out); end
    n_cmp++; if (b.changed !== 1'b0) begin n_err++; $display("FAIL loadsame_changed got=%b exp=0", b.changed); end
    n_cmp++; if (b.dwell_cnt !== 8'd1) begin n_err++; $display("FAIL loadsame_dwell got=%0d exp=1", b.dwell_cnt); end
    n_cmp++; if (b.prev_state !== 3'd1) begin n_err++; $display("FAIL loadsame_prev got=%0d exp=1", b.prev_state); end
    idle();
  endtask

  task automatic test_illegal();
    b.load = 1'b1; b.state_in = 3'd2;
    tick();
    n_cmp++; if (b.state_out !== 3'd2) begin n_err++; $display("FAIL ill_setup got=%0d exp=2", b.state_out); end
    b.state_in = 3'd7; b.adv = 1'b1;
    tick();
    n_cmp++; if (b.state_out !== 3'd2) begin n_err++; $display("FAIL ill_state got=%0d exp=2", b.state_out); end
    n_cmp++; if (b.illegal !== 1'b1) begin n_err++; $display("FAIL ill_flag got=%b exp=1", b.illegal); end
    n_cmp++; if (b.changed !== 1'b0) begin n_err++; $display("FAIL ill_changed got=%b exp=0", b.changed); end
    n_cmp++; if (b.dwell_cnt !== 8'd1) begin n_err++; $display("FAIL ill_dwell got=%0d exp=1", b.dwell_cnt); end
    b.adv = 1'b0; b.state_in = 3'd6; b.illegal_clr = 1'b1;
    tick();
    n_cmp++; if (b.illegal !== 1'b1) begin n_err++; $display("FAIL ill_setwins got=%b exp=1", b.illegal); end
    n_cmp++; if (b.state_out !== 3'd2) begin n_err++; $display("FAIL ill6_state got=%0d exp=2", b.state_out); end
    b.load = 1'b0;
    tick();
    n_cmp++; if (b.illegal !== 1'b0) begin n_err++; $display("FAIL ill_clr got=%b exp=0", b.illegal); end
    n_cmp++; if (b.dwell_cnt !== 8'd3) begin n_err++; $display("FAIL ill_dwell3 got=%0d exp=3", b.dwell_cnt); end
    idle();
  endtask

  task automatic test_stall();
    b.load = 1'b1; b.state_in = 3'd3;
    tick();
    b.state_in = 3'd6;
    tick();
    b.load = 1'b0;
    repeat (4) tick();
    n_cmp++; if (b.dwell_cnt !== 8'd5) begin n_err++; $display("FAIL stall_pre_dwell got=%0d exp=5", b.dwell_cnt); end
    b.en = 1'b0; b.adv = 1'b1; b.illegal_clr = 1'b1; b.load = 1'b1; b.state_in = 3'd0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (b.state_out !== 3'd3) begin n_err++; $display("FAIL stall_state[%0d] got=%0d exp=3", i, b.state_out); end
      n_cmp++; if (b.dwell_cnt !== 8'd5) begin n_err++; $display("FAIL stall_dwell[%0d] got=%0d exp=5", i, b.dwell_cnt); end
      n_cmp++; if (b.changed !== 1'b0) begin n_err++; $display("FAIL stall_changed[%0d] got=%b exp=0", i, b.changed); end
      n_cmp++; if (b.illegal !== 1'b1) begin n_err++; $display("FAIL stall_illegal[%0d] got=%b exp=1", i, b.illegal); end
      n_cmp++; if (b.prev_state !== 3'd2) begin n_err++; $display("FAIL stall_prev[%0d] got=%0d exp=2", i, b.prev_state); end
    end
    b.en = 1'b1; b.illegal_clr = 1'b0; b.load = 1'b0;
    tick();
    n_cmp++; if (b.state_out !== 3'd4) begin n_err++; $display("FAIL unstall_state got=%0d exp=4", b.state_out); end
    n_cmp++; if (b.dwell_cnt !== 8'd0) begin n_err++; $display("FAIL unstall_dwell got=%0d exp=0", b.dwell_cnt); end
    n_cmp++; if (b.prev_state !== 3'd3) begin n_err++; $display("FAIL unstall_prev got=%0d exp=3", b.prev_state); end
    idle();
  endtask

  task automatic test_mid_reset();
    b.load = 1'b1; b.state_in = 3'd5;
    tick();
    b.load = 1'b0;
    repeat (3) tick();
    n_cmp++; if (b.state_out !== 3'd5) begin n_err++; $display("FAIL mid_pre_state got=%0d exp=5", b.state_out); end
    n_cmp++; if (b.dwell_cnt !== 8'd3) begin n_err++; $display("FAIL mid_pre_dwell got=%0d exp=3", b.dwell_cnt); end
    n_cmp++; if (b.illegal !== 1'b1) begin n_err++; $display("FAIL mid_pre_illegal got=%b exp=1", b.illegal); end
    reset = 1'b0; b.adv = 1'b1;
    tick();
    n_cmp++; if (b.state_out !== 3'd0) begin n_err++; $display("FAIL mid_state got=%0d exp=0", b.state_out); end
    n_cmp++; if (b.prev_state !== 3'd0) begin n_err++; $display("FAIL mid_prev got=%0d exp=0", b.prev_state); end
    n_cmp++; if (b.dwell_cnt !== 8'd0) begin n_err++; $display("FAIL mid_dwell got=%0d exp=0", b.dwell_cnt); end
    n_cmp++; if (b.changed !== 1'b0) begin n_err++; $display("FAIL mid_changed got=%b exp=0", b.changed); end
    n_cmp++; if (b.illegal !== 1'b0) begin n_err++; $display("FAIL mid_illegal got=%b exp=0", b.illegal); end
    reset = 1'b1;
    tick();
    n_cmp++; if (b.state_out !== 3'd1) begin n_err++; $display("FAIL post_reset_state got=%0d exp=1", b.state_out); end
    n_cmp++; if (b.changed !== 1'b1) begin n_err++; $display("FAIL post_reset_changed got=%b exp=1", b.changed); end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [2:0] seq [3] = '{3'd5, 3'd0, 3'd3};
    logic [2:0] prv [3] = '{3'd1, 3'd5, 3'd0};
    b.load = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b.state_in = seq[i];
      tick();
      n_cmp++; if (b.state_out !== seq[i]) begin n_err++; $display("FAIL b2b_state[%0d] got=%0d exp=%0d", i, b.state_out, seq[i]); end
      n_cmp++; if (b.prev_state !== prv[i]) begin n_err++; $display("FAIL b2b_prev[%0d] got=%0d exp=%0d", i, b.prev_state, prv[i]); end
      n_cmp++; if (b.changed !== 1'b1) begin n_err++; $display("FAIL b2b_changed[%0d] got=%b exp=1", i, b.changed); end
    end
    b.load = 1'b0;
    tick();
    n_cmp++; if (b.changed !== 1'b0) begin n_err++; $display("FAIL b2b_drop got=%b exp=0", b.changed); end
    idle();
  endtask

  task automatic test_dwell_sat();
    logic [2:0] exp_d;
    b3.adv = 1'b1;
    tick();
    n_cmp++; if (b3.dwell_cnt !== 3'd0) begin n_err++; $display("FAIL sat_start got=%0d exp=0", b3.dwell_cnt); end
    b3.adv = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp_d = (i > 7) ? 3'd7 : 3'(i);
      n_cmp++; if (b3.dwell_cnt !== exp_d) begin n_err++; $display("FAIL sat_dwell[%0d] got=%0d exp=%0d", i, b3.dwell_cnt, exp_d); end
    end
    b3.adv = 1'b1;
    tick();
    n_cmp++; if (b3.dwell_cnt !== 3'd0) begin n_err++; $display("FAIL sat_after_adv got=%0d exp=0", b3.dwell_cnt); end
    n_cmp++; if (b3.state_out !== 3'd2) begin n_err++; $display("FAIL sat_state got=%0d exp=2", b3.state_out); end
    b3.adv = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    b3.en = 1'b1; b3.load = 1'b0; b3.state_in = '0; b3.adv = 1'b0; b3.illegal_clr = 1'b0;
    test_reset();
    test_advance_wrap();
    test_load_priority();
    test_illegal();
    test_stall();
    test_mid_reset();
    test_back_to_back();
    test_dwell_sat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cisc_state_seq.md
# cisc_state_seq

Parametrised control-step state register for the CISC core; the next generation of the 3-bit `state` register. It holds the current instruction-cycle state and supports:
- direct load or sequential advance with wrap-around;
- stall (clock-enable) gating;
- illegal-state rejection with a sticky flag;
- previous-state history, a per-state dwell counter and a one-cycle change pulse, used by the control decoder and debug logic.

## Interface
Parameters:
- STATE_W, 3, width of state encoding
- NUM_STATES, 6, legal states are 0..NUM_STATES-1; must satisfy 2 <= NUM_STATES <= 2**STATE_W
- RESET_STATE, 0, state after reset; must be < NUM_STATES
- CNT_W, 8, dwell counter width

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  reset, synchronous, active-low (0 = reset)
- en  input  1  step enable; 0 = stall, all registers hold
- load  input  1  load state_in as next state
- state_in  input  STATE_W  state to load
- adv  input  1  advance to next sequential state
- illegal_clr  input  1  clear sticky illegal flag
- state_out  output  STATE_W  current state
- prev_state  output  STATE_W  state held before the last actual change
- dwell_cnt  output  CNT_W  cycles spent in current state, saturating
- changed  output  1  high for one cycle after state_out changed
- illegal  output  1  sticky: a load of an out-of-range state was rejected

## Operation
- Reset (reset=0 at a clk edge) overrides every other input.
  - state_out = RESET_STATE, prev_state = RESET_STATE
  - dwell_cnt = 0, changed = 0, illegal = 0
- Next-state priority (reset=1): !en > load > adv > hold.
  - en=0: state_out, prev_state, dwell_cnt and illegal hold; changed = 0. illegal_clr is ignored while stalled.
  - load=1 and state_in < NUM_STATES: next = state_in.
  - load=1 and state_in >= NUM_STATES: load rejected, state holds, illegal set. adv in the same cycle is also ignored.
  - load=0, adv=1: next = state_out+1, or 0 when state_out == NUM_STATES-1 (wrap).
  - otherwise: hold.
- Actual change means next != state_out.
  - prev_state <= state_out
  - dwell_cnt <= 0
  - changed <= 1
- No change (hold, stall, rejected load, or a load of the current value):
  - prev_state holds, changed <= 0.
  - dwell_cnt increments when en=1 and saturates at 2**CNT_W-1.
  - dwell_cnt holds when en=0.
- illegal
  - Set on a rejected load.
  - Cleared by illegal_clr=1 with en=1.
  - Set wins over clear in the same cycle.
- Encodings >= NUM_STATES never appear on state_out.

## Timing
- All outputs registered. A request sampled at edge N is visible after edge N; latency is 1 cycle.
- changed is exactly one cycle wide per change. Consecutive changes on back-to-back cycles keep changed high continuously.
- dwell_cnt counts edges since the last change: 0 in the first cycle of a new state, 1 in the second, and so on.
- Reset mid-sequence takes effect at the next edge regardless of en, load or adv. Outputs return to reset values in 1 cycle.
- Inputs during reset are ignored; the first edge with reset=1 acts on the inputs normally.
- No combinational path from inputs to outputs.

## Test plan
- Reset/advance wrap (defaults): reset=0 for 2 edges, then adv=1 for 7 edges.
  - state_out sequence: 0,1,2,3,4,5,0,1.
  - changed=1 each cycle after the first advance.
  - prev_state trails state_out by one step.
- Load and priority: load=1, state_in=4, adv=1 -> state_out=4, not 1. Then load=1, state_in=4 again -> changed=0, dwell_cnt increments.
- Illegal load:
  - state_out=2, load=1, state_in=7 -> state_out stays 2, illegal=1.
  - Next cycle illegal_clr=1 together with load of 6 -> illegal stays 1.
  - Next cycle illegal_clr=1 alone -> illegal=0.
- Stall: state_out=3, dwell_cnt=5; en=0 with adv=1 and illegal_clr=1 for 4 edges -> state_out=3, dwell_cnt=5, changed=0, illegal unchanged. en=1, adv=1 -> state_out=4, dwell_cnt=0.
- Dwell saturation (CNT_W=3): hold 12 edges -> dwell_cnt counts 0..7 and stays 7. One advance -> 0.
- Mid-operation reset: in state 5 with dwell_cnt=3 and illegal=1, apply reset=0 together with adv=1 -> next edge shows state_out=0, prev_state=0, dwell_cnt=0, changed=0, illegal=0.
